// File: rtl/vga_pkg.sv
// Shared definitions for the slot display: default VGA timing, the RGB444
// pixel type, the 3-bit slot palette and the game-over flash colours.
package vga_pkg;

  localparam int   DEF_CLK_DIV      = 2;
  localparam int   DEF_H_ACTIVE     = 640;
  localparam int   DEF_H_FP         = 16;
  localparam int   DEF_H_SYNC       = 96;
  localparam int   DEF_H_BP         = 48;
  localparam int   DEF_V_ACTIVE     = 480;
  localparam int   DEF_V_FP         = 10;
  localparam int   DEF_V_SYNC       = 2;
  localparam int   DEF_V_BP         = 33;
  localparam logic DEF_SYNC_POL     = 1'b0;
  localparam int   DEF_NUM_SLOTS    = 4;
  localparam int   DEF_BORDER_W     = 4;
  localparam int   DEF_FLASH_FRAMES = 30;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic {
    FLASH_ON  = 1'b0,
    FLASH_OFF = 1'b1
  } flash_phase_t;

  localparam rgb444_t RGB_BLACK     = rgb444_t'(12'h000);
  localparam rgb444_t RGB_WHITE     = rgb444_t'(12'hFFF);
  localparam rgb444_t FLASH_ON_RGB  = rgb444_t'(12'hF00);
  localparam rgb444_t FLASH_OFF_RGB = rgb444_t'(12'h000);

  // Slot code to colour lookup.
  function automatic rgb444_t palette(input logic [2:0] code);
    rgb444_t c_s;
    case (code)
      3'd0:    c_s = rgb444_t'(12'h000);
      3'd1:    c_s = rgb444_t'(12'hF00);
      3'd2:    c_s = rgb444_t'(12'h0F0);
      3'd3:    c_s = rgb444_t'(12'h00F);
      3'd4:    c_s = rgb444_t'(12'hFF0);
      3'd5:    c_s = rgb444_t'(12'h0FF);
      3'd6:    c_s = rgb444_t'(12'hF0F);
      3'd7:    c_s = rgb444_t'(12'hFFF);
      default: c_s = rgb444_t'(12'h000);
    endcase
    return c_s;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider, horizontal/vertical counters,
// combinational sync/active decode and frame boundary strobes.
module vga_timing_gen #(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  HW       = $clog2(H_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pix_en,
  output logic [HW-1:0] h_cnt,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          frame_end,
  output logic          frame_begin
);

  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_r;
  logic [HW-1:0] h_cnt_r;
  logic [VW-1:0] v_cnt_r;
  logic          line_end_s;
  logic          frame_last_s;

  // Pixel-enable divider; the tick fires on the first cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r <= {DW{1'b0}};
    end else if (div_r == DIV_LAST) begin
      div_r <= {DW{1'b0}};
    end else begin
      div_r <= div_r + {{(DW-1){1'b0}}, 1'b1};
    end
  end

  assign pix_en       = (div_r == {DW{1'b0}});
  assign line_end_s   = (h_cnt_r == H_LAST);
  assign frame_last_s = line_end_s && (v_cnt_r == V_LAST);

  // Horizontal pixel counter, advancing on each pixel tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_r <= {HW{1'b0}};
    end else if (pix_en) begin
      h_cnt_r <= line_end_s ? {HW{1'b0}} : h_cnt_r + {{(HW-1){1'b0}}, 1'b1};
    end else begin
      h_cnt_r <= h_cnt_r;
    end
  end

  // Vertical line counter, advancing at the end of each line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_cnt_r <= {VW{1'b0}};
    end else if (pix_en && line_end_s) begin
      v_cnt_r <= (v_cnt_r == V_LAST) ? {VW{1'b0}} : v_cnt_r + {{(VW-1){1'b0}}, 1'b1};
    end else begin
      v_cnt_r <= v_cnt_r;
    end
  end

  assign h_cnt       = h_cnt_r;
  assign hsync       = ((h_cnt_r >= HS_START) && (h_cnt_r < HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vsync       = ((v_cnt_r >= VS_START) && (v_cnt_r < VS_END)) ? SYNC_POL : ~SYNC_POL;
  assign active      = (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);
  assign frame_end   = pix_en && frame_last_s;
  assign frame_begin = pix_en && (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});

endmodule

// File: rtl/vga_slot_display.sv
// Slot-column VGA renderer: per-frame shadow of slot codes and game-over,
// slot/divider decode, game-over flash FSM and a single registered output
// stage that keeps sync and colour aligned.
module vga_slot_display
  import vga_pkg::*;
#(
  parameter int   CLK_DIV      = DEF_CLK_DIV,
  parameter int   H_ACTIVE     = DEF_H_ACTIVE,
  parameter int   H_FP         = DEF_H_FP,
  parameter int   H_SYNC       = DEF_H_SYNC,
  parameter int   H_BP         = DEF_H_BP,
  parameter int   V_ACTIVE     = DEF_V_ACTIVE,
  parameter int   V_FP         = DEF_V_FP,
  parameter int   V_SYNC       = DEF_V_SYNC,
  parameter int   V_BP         = DEF_V_BP,
  parameter logic SYNC_POL     = DEF_SYNC_POL,
  parameter int   NUM_SLOTS    = DEF_NUM_SLOTS,
  parameter int   BORDER_W     = DEF_BORDER_W,
  parameter int   FLASH_FRAMES = DEF_FLASH_FRAMES
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [3*NUM_SLOTS-1:0] colourCode,
  input  logic                   GameOver,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic [3:0]             VGA_R,
  output logic [3:0]             VGA_G,
  output logic [3:0]             VGA_B,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int SLOT_W  = H_ACTIVE / NUM_SLOTS;
  localparam int SLW     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int FW      = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int CW      = 3 * NUM_SLOTS;

  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [HW-1:0] BORDER_LIM = HW'(BORDER_W);

  logic              pix_en_s;
  logic [HW-1:0]     h_cnt_s;
  logic              hsync_s;
  logic              vsync_s;
  logic              active_s;
  logic              frame_end_s;
  logic              frame_begin_s;

  logic [CW-1:0]     code_sh_r;
  logic              go_sh_r;
  flash_phase_t      phase_r;
  flash_phase_t      phase_nx_s;
  logic [FW-1:0]     fcnt_r;
  logic [FW-1:0]     fcnt_nx_s;

  logic [SLW-1:0]    slot_s;
  logic [HW-1:0]     slot_base_s;
  logic [HW-1:0]     offset_s;
  logic              border_s;
  logic [2:0]        slot_code_s;
  rgb444_t           pix_rgb_s;

  logic              hs_r;
  logic              vs_r;
  rgb444_t           rgb_r;
  logic              frame_start_r;

  vga_timing_gen #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk         (CLOCK_50),
    .rst         (reset),
    .pix_en      (pix_en_s),
    .h_cnt       (h_cnt_s),
    .hsync       (hsync_s),
    .vsync       (vsync_s),
    .active      (active_s),
    .frame_end   (frame_end_s),
    .frame_begin (frame_begin_s)
  );

  // Shadow the game inputs on the last tick of each frame so a frame never tears.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      code_sh_r <= {CW{1'b0}};
      go_sh_r   <= 1'b0;
    end else if (frame_end_s) begin
      code_sh_r <= colourCode;
      go_sh_r   <= GameOver;
    end else begin
      code_sh_r <= code_sh_r;
      go_sh_r   <= go_sh_r;
    end
  end

  // Flash FSM state register: phase plus frames spent in the current phase.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      phase_r <= FLASH_ON;
      fcnt_r  <= {FW{1'b0}};
    end else begin
      phase_r <= phase_nx_s;
      fcnt_r  <= fcnt_nx_s;
    end
  end

  // Flash next state: count frames that stay in game-over, restart ON otherwise.
  always_comb begin
    phase_nx_s = phase_r;
    fcnt_nx_s  = fcnt_r;
    if (frame_end_s) begin
      if (GameOver && go_sh_r) begin
        if (fcnt_r == FLASH_LAST) begin
          fcnt_nx_s = {FW{1'b0}};
          case (phase_r)
            FLASH_ON:  phase_nx_s = FLASH_OFF;
            FLASH_OFF: phase_nx_s = FLASH_ON;
            default:   phase_nx_s = FLASH_ON;
          endcase
        end else begin
          fcnt_nx_s = fcnt_r + {{(FW-1){1'b0}}, 1'b1};
        end
      end else begin
        fcnt_nx_s  = {FW{1'b0}};
        phase_nx_s = FLASH_ON;
      end
    end else begin
      phase_nx_s = phase_r;
      fcnt_nx_s  = fcnt_r;
    end
  end

  // Slot decode by comparing against each column's start; the last match wins.
  always_comb begin
    slot_s      = {SLW{1'b0}};
    slot_base_s = {HW{1'b0}};
    for (int i = 1; i < NUM_SLOTS; i++) begin
      slot_s      = (h_cnt_s >= HW'(i * SLOT_W)) ? SLW'(i) : slot_s;
      slot_base_s = (h_cnt_s >= HW'(i * SLOT_W)) ? HW'(i * SLOT_W) : slot_base_s;
    end
    offset_s    = h_cnt_s - slot_base_s;
    border_s    = (slot_s != {SLW{1'b0}}) && (offset_s < BORDER_LIM);
    slot_code_s = code_sh_r[3*int'(slot_s) +: 3];
  end

  // Pixel colour with priority flash > divider > palette; black in blanking.
  always_comb begin
    pix_rgb_s = RGB_BLACK;
    if (!active_s) begin
      pix_rgb_s = RGB_BLACK;
    end else if (go_sh_r) begin
      pix_rgb_s = (phase_r == FLASH_ON) ? FLASH_ON_RGB : FLASH_OFF_RGB;
    end else if (border_s) begin
      pix_rgb_s = RGB_WHITE;
    end else begin
      pix_rgb_s = palette(slot_code_s);
    end
  end

  // Output stage: sync and colour registered together on the pixel tick.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hs_r  <= ~SYNC_POL;
      vs_r  <= ~SYNC_POL;
      rgb_r <= RGB_BLACK;
    end else if (pix_en_s) begin
      hs_r  <= hsync_s;
      vs_r  <= vsync_s;
      rgb_r <= pix_rgb_s;
    end else begin
      hs_r  <= hs_r;
      vs_r  <= vs_r;
      rgb_r <= rgb_r;
    end
  end

  // Frame start pulse, one system clock wide, coincident with pixel (0,0) on the pins.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= frame_begin_s;
    end
  end

  assign VGA_HS      = hs_r;
  assign VGA_VS      = vs_r;
  assign VGA_R       = rgb_r.r;
  assign VGA_G       = rgb_r.g;
  assign VGA_B       = rgb_r.b;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_slot_display.sv
// Bench for vga_slot_display with a reduced raster so many frames fit in a
// short run. Two instances: A (CLK_DIV=2, active-low sync, 4 slots) and
// B (CLK_DIV=1, active-high sync, 8 slots). A cycle-level reference model
// pushes the expected pins of each instance before every clock edge; the
// entries are popped and compared just after the edge.
module tb_vga_slot_display;

  localparam int HA = 16, HF = 2, HS = 3, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int BW = 1;

  typedef struct {
    int          inst;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        fs;
  } exp_t;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic [11:0] code_a = 12'h000;
  logic [23:0] code_b = 24'h000000;
  logic        go     = 1'b0;

  logic       hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  int   cfg_div   [2] = '{2, 1};
  int   cfg_slots [2] = '{4, 8};
  logic cfg_pol   [2] = '{1'b0, 1'b1};
  int   cfg_ff    [2] = '{2, 3};

  int          m_cyc  [2];
  int          m_h    [2];
  int          m_v    [2];
  logic [23:0] m_code [2];
  logic        m_go   [2];
  int          m_gof  [2];
  exp_t        m_hold [2];

  always #5 clk = ~clk;

  vga_slot_display #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0),
    .NUM_SLOTS(4), .BORDER_W(BW), .FLASH_FRAMES(2)
  ) u_dut_a (
    .CLOCK_50(clk), .reset(reset), .colourCode(code_a), .GameOver(go),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a),
    .frame_start(fs_a)
  );

  vga_slot_display #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1),
    .NUM_SLOTS(8), .BORDER_W(BW), .FLASH_FRAMES(3)
  ) u_dut_b (
    .CLOCK_50(clk), .reset(reset), .colourCode(code_b), .GameOver(go),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b),
    .frame_start(fs_b)
  );

  function automatic logic [11:0] pal(input logic [2:0] c);
    case (c)
      3'd0:    return 12'h000;
      3'd1:    return 12'hF00;
      3'd2:    return 12'h0F0;
      3'd3:    return 12'h00F;
      3'd4:    return 12'hFF0;
      3'd5:    return 12'h0FF;
      3'd6:    return 12'hF0F;
      default: return 12'hFFF;
    endcase
  endfunction

  function automatic logic [11:0] exp_rgb(input int i, input int h, input int v);
    int sw;
    int slot;
    if (h >= HA || v >= VA) return 12'h000;
    if (m_go[i]) return (((m_gof[i] / cfg_ff[i]) % 2) == 0) ? 12'hF00 : 12'h000;
    sw   = HA / cfg_slots[i];
    slot = h / sw;
    if (slot > 0 && (h % sw) < BW) return 12'hFFF;
    return pal(m_code[i][slot*3 +: 3]);
  endfunction

  task automatic model_reset(input int i);
    m_cyc[i]       = 0;
    m_h[i]         = 0;
    m_v[i]         = 0;
    m_code[i]      = 24'h000000;
    m_go[i]        = 1'b0;
    m_gof[i]       = 0;
    m_hold[i].inst = i;
    m_hold[i].hs   = ~cfg_pol[i];
    m_hold[i].vs   = ~cfg_pol[i];
    m_hold[i].rgb  = 12'h000;
    m_hold[i].fs   = 1'b0;
  endtask

  // Predict the pins of instance i after the coming clock edge.
  task automatic model_step(input int i);
    exp_t        e;
    logic [23:0] in_code;
    in_code = (i == 0) ? {12'h000, code_a} : code_b;
    if ((m_cyc[i] % cfg_div[i]) == 0) begin
      e.inst = i;
      e.hs   = (m_h[i] >= HA + HF && m_h[i] < HA + HF + HS) ? cfg_pol[i] : ~cfg_pol[i];
      e.vs   = (m_v[i] >= VA + VF && m_v[i] < VA + VF + VS) ? cfg_pol[i] : ~cfg_pol[i];
      e.rgb  = exp_rgb(i, m_h[i], m_v[i]);
      e.fs   = (m_h[i] == 0 && m_v[i] == 0);
      if (m_h[i] == HT - 1 && m_v[i] == VT - 1) begin
        m_gof[i]  = (go && m_go[i]) ? m_gof[i] + 1 : 0;
        m_go[i]   = go;
        m_code[i] = in_code;
      end
      if (m_h[i] == HT - 1) begin
        m_h[i] = 0;
        m_v[i] = (m_v[i] == VT - 1) ? 0 : m_v[i] + 1;
      end else begin
        m_h[i] = m_h[i] + 1;
      end
    end else begin
      e    = m_hold[i];
      e.fs = 1'b0;
    end
    m_hold[i] = e;
    m_cyc[i]  = m_cyc[i] + 1;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic        hs, vs, fs;
    logic [11:0] rgb;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.inst == 0) begin
        hs = hs_a; vs = vs_a; fs = fs_a; rgb = {r_a, g_a, b_a};
      end else begin
        hs = hs_b; vs = vs_b; fs = fs_b; rgb = {r_b, g_b, b_b};
      end
      n_vec++;
      assert ({hs, vs} === {e.hs, e.vs}) else begin
        n_err++;
        $error("FAIL sync[%0d] t=%0t observed hs/vs=%b%b expected %b%b", e.inst, $time, hs, vs, e.hs, e.vs);
      end
      n_vec++;
      assert (rgb === e.rgb) else begin
        n_err++;
        $error("FAIL rgb[%0d] t=%0t observed %h expected %h", e.inst, $time, rgb, e.rgb);
      end
      n_vec++;
      assert (fs === e.fs) else begin
        n_err++;
        $error("FAIL frame_start[%0d] t=%0t observed %b expected %b", e.inst, $time, fs, e.fs);
      end
    end
  endtask

  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Reset is asserted now: both instances must show reset values on their pins.
  task automatic reset_check();
    model_reset(0);
    model_reset(1);
    sb.push_back(m_hold[0]);
    sb.push_back(m_hold[1]);
    check_out();
  endtask

  initial begin
    // Power-on reset across a clock edge, then release between edges.
    @(posedge clk);
    #1;
    reset_check();
    @(posedge clk);
    #1;
    reset_check();
    reset  = 1'b0;
    code_a = {3'd7, 3'd3, 3'd2, 3'd1};
    code_b = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    // First frame shows reset shadows (black), later frames the slot colours.
    run(2 * HT * VT * 2);

    // Mid-frame code change takes effect only from the next frame.
    run(700);
    code_a = {3'd4, 3'd5, 3'd6, 3'd0};
    code_b = {3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    run(600);

    // Game-over flash over several frames, then mid-frame deassert.
    go = 1'b1;
    run(2900);
    go = 1'b0;
    run(1000);

    // Mid-frame reset while instance A is on line 3.
    for (int k = 0; k < 2 * HT * VT * 2 && m_v[0] != 3; k++) cycle();
    reset = 1'b1;
    #1;
    reset_check();
    @(posedge clk);
    #1;
    reset_check();
    reset = 1'b0;
    go    = 1'b1;
    run(1200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
